// File: rtl/bert_pkg.sv
// Shared definitions for the bit error tester datapath.
// Used by both the channel delay line and the receive-side aligner.
package bert_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FLUSH,
        SEARCH,
        LOCKED,
        FAIL
    } state_t;

    localparam int CAND_COUNT = 4;
    localparam int TAP_OFFSET = 2;
    localparam int FLUSH_BITS = 6;
    localparam int HIST_W     = 6;
    localparam int MIN_DELAY  = 3;

    // Delay code 0..3 selects a 3..6 bit channel delay.
    function automatic int delay_bits(input logic [1:0] code);
        return MIN_DELAY + int'(code);
    endfunction

endpackage

// File: rtl/delay_aligner_if.sv
// Bit stream inputs and alignment status of the delay aligner.
// The stimulus side drives as master, the aligner sits on slave.
interface delay_aligner_if #(
    parameter int ERR_W = 16,
    parameter int BIT_W = 32
);

    logic             enable;
    logic             start;
    logic             ref_in;
    logic             rx_in;
    logic [1:0]       delay_found;
    logic             locked;
    logic             search_fail;
    logic             busy;
    logic [ERR_W-1:0] error_count;
    logic [BIT_W-1:0] bit_count;

    modport master (
        output enable,
        output start,
        output ref_in,
        output rx_in,
        input  delay_found,
        input  locked,
        input  search_fail,
        input  busy,
        input  error_count,
        input  bit_count
    );

    modport slave (
        input  enable,
        input  start,
        input  ref_in,
        input  rx_in,
        output delay_found,
        output locked,
        output search_fail,
        output busy,
        output error_count,
        output bit_count
    );

endinterface

// File: rtl/ref_history.sv
// Enabled 6-bit reference shift register with a delay-code tap.
// Tap c returns the bit shifted in c+3 enabled strobes ago.
module ref_history
    import bert_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_en,
    input  logic       i_d,
    input  logic [1:0] i_sel,
    output logic       o_tap
);

    logic [HIST_W-1:0] r_hist;
    logic [2:0]        w_idx;

    assign w_idx = {1'b0, i_sel} + 3'(TAP_OFFSET);
    assign o_tap = r_hist[w_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist <= '0;
        end else if (i_en) begin
            r_hist <= {r_hist[HIST_W-2:0], i_d};
        end
    end

endmodule

// File: rtl/delay_aligner.sv
// Searches the four channel delays for an error-free window, then
// tracks bit/error counts and drops lock on excessive errors.
module delay_aligner
    import bert_pkg::*;
#(
    parameter int WINDOW   = 32,
    parameter int MAX_LOSS = 4,
    parameter int ERR_W    = 16,
    parameter int BIT_W    = 32
) (
    input logic            clk,
    input logic            reset,
    delay_aligner_if.slave bus
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_BITS - 1);
    localparam logic [CNT_W-1:0] LOSS_LIM   = CNT_W'(MAX_LOSS);
    localparam logic [1:0]       CAND_LAST  = 2'(CAND_COUNT - 1);

    state_t           r_state, n_state;
    logic [1:0]       r_cand, n_cand;
    logic [1:0]       r_found, n_found;
    logic [CNT_W-1:0] r_cnt, n_cnt;
    logic [CNT_W-1:0] r_loss, n_loss;
    logic             r_dirty, n_dirty;
    logic             r_locked, n_locked;
    logic             r_fail, n_fail;
    logic             r_busy;
    logic [ERR_W-1:0] r_err, n_err;
    logic [BIT_W-1:0] r_bits, n_bits;

    logic             w_tap;
    logic             w_mis;
    logic             w_dirty;
    logic [1:0]       w_sel;
    logic [CNT_W-1:0] w_loss;

    // While locked the tap follows the found delay, otherwise the candidate.
    assign w_sel   = (r_state == LOCKED) ? r_found : r_cand;
    assign w_mis   = bus.rx_in ^ w_tap;
    assign w_dirty = r_dirty | w_mis;
    assign w_loss  = r_loss + CNT_W'(w_mis);

    ref_history u_hist (
        .clk   (clk),
        .reset (reset),
        .i_en  (bus.enable),
        .i_d   (bus.ref_in),
        .i_sel (w_sel),
        .o_tap (w_tap)
    );

    always_comb begin
        n_state  = r_state;
        n_cand   = r_cand;
        n_found  = r_found;
        n_cnt    = r_cnt;
        n_loss   = r_loss;
        n_dirty  = r_dirty;
        n_locked = r_locked;
        n_fail   = r_fail;
        n_err    = r_err;
        n_bits   = r_bits;
        if (bus.start) begin
            n_state  = FLUSH;
            n_cand   = '0;
            n_cnt    = '0;
            n_loss   = '0;
            n_dirty  = 1'b0;
            n_locked = 1'b0;
            n_fail   = 1'b0;
            n_err    = '0;
            n_bits   = '0;
        end else if (bus.enable) begin
            case (r_state)
                FLUSH: begin
                    if (r_cnt == FLUSH_LAST) begin
                        n_state = SEARCH;
                        n_cnt   = '0;
                        n_cand  = '0;
                        n_dirty = 1'b0;
                    end else begin
                        n_cnt = r_cnt + CNT_W'(1);
                    end
                end
                SEARCH: begin
                    if (r_cnt == WIN_LAST) begin
                        n_cnt   = '0;
                        n_dirty = 1'b0;
                        n_loss  = '0;
                        if (!w_dirty) begin
                            n_state  = LOCKED;
                            n_found  = r_cand;
                            n_locked = 1'b1;
                        end else if (r_cand == CAND_LAST) begin
                            n_state = FAIL;
                            n_fail  = 1'b1;
                        end else begin
                            n_cand = r_cand + 2'd1;
                        end
                    end else begin
                        n_cnt   = r_cnt + CNT_W'(1);
                        n_dirty = w_dirty;
                    end
                end
                LOCKED: begin
                    if (r_bits != '1) begin
                        n_bits = r_bits + BIT_W'(1);
                    end
                    if (w_mis && (r_err != '1)) begin
                        n_err = r_err + ERR_W'(1);
                    end
                    if (w_loss == LOSS_LIM) begin
                        n_state  = SEARCH;
                        n_cand   = '0;
                        n_cnt    = '0;
                        n_loss   = '0;
                        n_dirty  = 1'b0;
                        n_locked = 1'b0;
                    end else if (r_cnt == WIN_LAST) begin
                        n_cnt  = '0;
                        n_loss = '0;
                    end else begin
                        n_cnt  = r_cnt + CNT_W'(1);
                        n_loss = w_loss;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cand   <= '0;
            r_found  <= '0;
            r_cnt    <= '0;
            r_loss   <= '0;
            r_dirty  <= 1'b0;
            r_locked <= 1'b0;
            r_fail   <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= '0;
            r_bits   <= '0;
        end else begin
            r_state  <= n_state;
            r_cand   <= n_cand;
            r_found  <= n_found;
            r_cnt    <= n_cnt;
            r_loss   <= n_loss;
            r_dirty  <= n_dirty;
            r_locked <= n_locked;
            r_fail   <= n_fail;
            r_busy   <= (n_state == FLUSH) || (n_state == SEARCH);
            r_err    <= n_err;
            r_bits   <= n_bits;
        end
    end

    assign bus.delay_found = r_found;
    assign bus.locked      = r_locked;
    assign bus.search_fail = r_fail;
    assign bus.busy        = r_busy;
    assign bus.error_count = r_err;
    assign bus.bit_count   = r_bits;

endmodule

// File: tb/tb_delay_aligner.sv
// Random and directed stimulus for delay_aligner against a
// bit-history reference model; two instances cover counter widths.
module tb_delay_aligner;

    localparam int WINDOW   = 32;
    localparam int MAX_LOSS = 4;
    localparam int FLUSH_N  = 6;
    localparam int MI = 0, MF = 1, MS = 2, ML = 3, MX = 4;
    localparam int R_PRBS = 0, R_RAND = 1, R_CONST = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic en, st, rf, rx;

    delay_aligner_if #(.ERR_W(16), .BIT_W(32)) bus_a ();
    delay_aligner_if #(.ERR_W(4),  .BIT_W(8))  bus_b ();

    assign bus_a.enable = en;
    assign bus_a.start  = st;
    assign bus_a.ref_in = rf;
    assign bus_a.rx_in  = rx;
    assign bus_b.enable = en;
    assign bus_b.start  = st;
    assign bus_b.ref_in = rf;
    assign bus_b.rx_in  = rx;

    delay_aligner #(
        .WINDOW(WINDOW), .MAX_LOSS(MAX_LOSS),
        .ERR_W(16), .BIT_W(32)
    ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

    delay_aligner #(
        .WINDOW(WINDOW), .MAX_LOSS(MAX_LOSS),
        .ERR_W(4), .BIT_W(8)
    ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // stimulus state
    bit       txlog[$];
    logic [6:0] lfsr = 7'h7F;
    int       d = 0;
    bit       inv = 1'b0;
    int       period = 1;
    bit       rnd_en = 1'b0;
    int       ref_mode = R_PRBS;
    int       cyc = 0;

    // model state
    int     m_mode = MI;
    int     m_n, m_mm, m_cand, m_found;
    bit     m_locked, m_fail;
    longint m_err, m_bits;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic bit past(input int j);
        int k;
        k = txlog.size() - j;
        return (k >= 0) ? txlog[k] : 1'b0;
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    function automatic bit next_ref();
        bit b;
        case (ref_mode)
            R_PRBS: begin
                b = lfsr[6] ^ lfsr[5];
                lfsr = {lfsr[5:0], b};
            end
            R_RAND:  b = 1'($urandom_range(0, 1));
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    task automatic model_clear();
        m_mode = MI; m_n = 0; m_mm = 0; m_cand = 0;
        m_found = 0; m_locked = 0; m_fail = 0;
        m_err = 0; m_bits = 0;
    endtask

    // One edge of the block, evaluated from the window rules.
    task automatic model_step();
        bit mis;
        int sel;
        sel = (m_mode == ML) ? m_found : m_cand;
        mis = (rx != past(sel + 3));
        if (st) begin
            m_mode = MF; m_n = 0; m_mm = 0; m_cand = 0;
            m_locked = 0; m_fail = 0; m_err = 0; m_bits = 0;
            return;
        end
        if (!en) return;
        case (m_mode)
            MF: begin
                m_n++;
                if (m_n == FLUSH_N) begin
                    m_mode = MS; m_n = 0; m_mm = 0; m_cand = 0;
                end
            end
            MS: begin
                m_n++;
                m_mm += int'(mis);
                if (m_n == WINDOW) begin
                    if (m_mm == 0) begin
                        m_mode = ML; m_found = m_cand; m_locked = 1;
                    end else if (m_cand == 3) begin
                        m_mode = MX; m_fail = 1;
                    end else begin
                        m_cand++;
                    end
                    m_n = 0; m_mm = 0;
                end
            end
            ML: begin
                m_bits++;
                m_err += longint'(mis);
                m_n++;
                m_mm += int'(mis);
                if (m_mm == MAX_LOSS) begin
                    m_mode = MS; m_cand = 0; m_locked = 0;
                    m_n = 0; m_mm = 0;
                end else if (m_n == WINDOW) begin
                    m_n = 0; m_mm = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        bit busy_exp;
        busy_exp = (m_mode == MF) || (m_mode == MS);
        check("locked", 64'(bus_a.locked), 64'(m_locked));
        check("found", 64'(bus_a.delay_found), 64'(m_found));
        check("fail", 64'(bus_a.search_fail), 64'(m_fail));
        check("busy", 64'(bus_a.busy), 64'(busy_exp));
        check("err_a", 64'(bus_a.error_count), 64'(sat(m_err, 16)));
        check("bits_a", 64'(bus_a.bit_count), 64'(sat(m_bits, 32)));
        check("err_b", 64'(bus_b.error_count), 64'(sat(m_err, 4)));
        check("bits_b", 64'(bus_b.bit_count), 64'(sat(m_bits, 8)));
    endtask

    task automatic step(input bit s, input bit f);
        if (rnd_en)
            en = ($urandom_range(0, period - 1) == 0);
        else
            en = ((cyc % period) == 0);
        st = s;
        if (en) rf = next_ref();
        rx = past(d + 3) ^ inv ^ f;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
        if (en) txlog.push_back(rf);
        cyc++;
        st = 1'b0;
    endtask

    task automatic run_until_lock(input int budget, output int nb);
        nb = 0;
        for (int k = 0; k < budget; k++) begin
            step(1'b0, 1'b0);
            if (en) nb++;
            if (bus_a.locked) return;
        end
        nb = -1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check("rst_locked", 64'(bus_a.locked), 64'(0));
        check("rst_found", 64'(bus_a.delay_found), 64'(0));
        check("rst_fail", 64'(bus_a.search_fail), 64'(0));
        check("rst_busy", 64'(bus_a.busy), 64'(0));
        check("rst_err", 64'(bus_a.error_count), 64'(0));
        check("rst_bits", 64'(bus_a.bit_count), 64'(0));
        model_clear();
        txlog.delete();
        en = 1'b1;
        st = 1'b1;
        @(posedge clk);
        #1;
        check("rst_start_busy", 64'(bus_a.busy), 64'(0));
        check("rst_start_lock", 64'(bus_a.locked), 64'(0));
        reset = 1'b0;
        st = 1'b0;
        cyc++;
        for (int k = 0; k < 8; k++) step(1'b0, 1'b0);
    endtask

    initial begin
        int nb;
        en = 0; st = 0; rf = 0; rx = 0;
        model_clear();
        #1;
        do_reset();

        // delay 2, continuous enable
        d = 2;
        step(1'b1, 1'b0);
        run_until_lock(300, nb);
        check("lock_lat_d2", 64'(nb), 64'(FLUSH_N + 3 * WINDOW));
        check("found_d2", 64'(bus_a.delay_found), 64'(2));
        check("err_d2", 64'(bus_a.error_count), 64'(0));

        // delay 3, enable one cycle in three
        d = 3;
        period = 3;
        step(1'b1, 1'b0);
        run_until_lock(900, nb);
        check("lock_lat_d3", 64'(nb), 64'(FLUSH_N + 4 * WINDOW));
        check("found_d3", 64'(bus_a.delay_found), 64'(3));
        period = 1;

        // loss of lock at delay 1
        d = 1;
        step(1'b1, 1'b0);
        run_until_lock(300, nb);
        check("found_d1", 64'(bus_a.delay_found), 64'(1));
        for (int j = 0; j < WINDOW; j++)
            step(1'b0, (j == 5) || (j == 10) || (j == 15));
        check("err_3", 64'(bus_a.error_count), 64'(3));
        check("hold_lock", 64'(bus_a.locked), 64'(1));
        for (int j = 0; j < WINDOW; j++) begin
            step(1'b0, (j == 2) || (j == 6) || (j == 10) || (j == 14));
            if (j == 13)
                check("pre_loss", 64'(bus_a.locked), 64'(1));
            if (j == 14) begin
                check("loss_4th", 64'(bus_a.locked), 64'(0));
                break;
            end
        end
        check("err_7", 64'(bus_a.error_count), 64'(7));
        run_until_lock(300, nb);
        check("relock_lat", 64'(nb), 64'(2 * WINDOW));
        check("relock_found", 64'(bus_a.delay_found), 64'(1));

        // inverted receive stream never aligns
        d = 0;
        inv = 1'b1;
        step(1'b1, 1'b0);
        for (int k = 1; k <= FLUSH_N + 4 * WINDOW; k++) begin
            step(1'b0, 1'b0);
            if (k == FLUSH_N + 4 * WINDOW - 1)
                check("fail_early", 64'(bus_a.search_fail), 64'(0));
        end
        check("fail_rise", 64'(bus_a.search_fail), 64'(1));
        check("fail_unlock", 64'(bus_a.locked), 64'(0));
        step(1'b1, 1'b0);
        check("fail_clear", 64'(bus_a.search_fail), 64'(0));
        inv = 1'b0;

        // error and bit counter saturation
        d = 0;
        step(1'b1, 1'b0);
        run_until_lock(300, nb);
        check("lock_lat_d0", 64'(nb), 64'(FLUSH_N + WINDOW));
        for (int j = 0; j < 800; j++)
            step(1'b0, (j % 40) == 20);
        check("sat_err_a", 64'(bus_a.error_count), 64'(20));
        check("sat_err_b", 64'(bus_b.error_count), 64'(15));
        check("sat_bits_b", 64'(bus_b.bit_count), 64'(255));
        check("sat_bits_a", 64'(bus_a.bit_count), 64'(800));
        check("sat_locked", 64'(bus_a.locked), 64'(1));

        // constant reference locks on candidate 0
        ref_mode = R_CONST;
        d = 2;
        step(1'b1, 1'b0);
        run_until_lock(300, nb);
        check("const_found", 64'(bus_a.delay_found), 64'(0));
        ref_mode = R_PRBS;

        // reset during SEARCH and during LOCKED
        d = 1;
        step(1'b1, 1'b0);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b0);
        check("in_search", 64'(bus_a.busy), 64'(1));
        do_reset();
        d = 0;
        step(1'b1, 1'b0);
        run_until_lock(300, nb);
        check("pre_rst_lock", 64'(bus_a.locked), 64'(1));
        do_reset();

        // random streams, delays, enables and error bursts
        ref_mode = R_RAND;
        rnd_en = 1'b1;
        for (int r = 0; r < 8; r++) begin
            d = $urandom_range(0, 3);
            period = $urandom_range(1, 3);
            step(1'b1, 1'b0);
            for (int k = 0; k < 450; k++)
                step(1'b0, $urandom_range(0, 63) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
